// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: handshake/status bundle between a FIFO client and fifo_ctrl.
//   master modport : client side, drives requests and thresholds, sees status
//   slave  modport : fifo_ctrl side, drives pointers, strobes and flags
// Signals:
//   push_req/pop_req   client requests for this cycle
//   th_af/th_ae        almost-full / almost-empty thresholds
//   wr_ptr/rd_ptr      memory addresses (registered)
//   push/pop           qualified memory strobes (combinational)
//   fifo_count         occupancy 0..MEM_SIZE
//   full/empty         registered boundary flags
//   almost_full/_empty threshold compares on the registered count
//   err_overflow/_underflow sticky request-while-full/empty flags
interface fifo_ctrl_if #(
  parameter int PTR_L = 3
);
  logic             push_req;
  logic             pop_req;
  logic [PTR_L-1:0] th_af;
  logic [PTR_L-1:0] th_ae;
  logic [PTR_L-1:0] wr_ptr;
  logic [PTR_L-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [PTR_L-1:0] fifo_count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             err_overflow;
  logic             err_underflow;

  modport master (
    output push_req, pop_req, th_af, th_ae,
    input  wr_ptr, rd_ptr, push, pop, fifo_count, full, empty,
           almost_full, almost_empty, err_overflow, err_underflow
  );

  modport slave (
    input  push_req, pop_req, th_af, th_ae,
    output wr_ptr, rd_ptr, push, pop, fifo_count, full, empty,
           almost_full, almost_empty, err_overflow, err_underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/occupancy controller for the FIFO memory bank.
// The data path bypasses this block; it only drives the memory's wr_ptr,
// rd_ptr, push and pop, and reports occupancy and error status.
// Ports:
//   clk      single clock, rising edge
//   reset_L  synchronous active-low reset
//   bus      fifo_ctrl_if.slave (requests, thresholds in; pointers, strobes,
//            count and flags out)
module fifo_ctrl #(
  parameter int MEM_SIZE  = 4,
  parameter int WORD_SIZE = 6,
  parameter int PTR_L     = 3
) (
  input  logic        clk,
  input  logic        reset_L,
  fifo_ctrl_if.slave  bus
);

  // The count must be able to hold MEM_SIZE; WORD_SIZE only passes through.
  if (MEM_SIZE > (2**PTR_L) - 1 || MEM_SIZE < 1 || WORD_SIZE < 1) begin : g_bad_params
    $error("fifo_ctrl: bad parameters MEM_SIZE=%0d PTR_L=%0d WORD_SIZE=%0d",
           MEM_SIZE, PTR_L, WORD_SIZE);
  end

  localparam logic [PTR_L-1:0] LAST  = PTR_L'(MEM_SIZE - 1);
  localparam logic [PTR_L-1:0] DEPTH = PTR_L'(MEM_SIZE);

  logic [PTR_L-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_L-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_L-1:0] count_q,  count_d;
  logic             full_q,   full_d;
  logic             empty_q,  empty_d;
  logic             ovf_q,    ovf_d;
  logic             unf_q,    unf_d;
  logic             push, pop;

  // Boundaries judged on registered state only: full+both accepts just the
  // pop, empty+both just the push, so one entry is never read and written
  // in the same cycle.
  assign push = reset_L & bus.push_req & ~full_q;
  assign pop  = reset_L & bus.pop_req  & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Flags come from the next count so they always agree with fifo_count.
    full_d  = (count_d == DEPTH);
    empty_d = (count_d == '0);
    // Sticky errors look at the raw request, not the qualified strobe.
    ovf_d   = ovf_q | (bus.push_req & full_q);
    unf_d   = unf_q | (bus.pop_req  & empty_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.wr_ptr        = wr_ptr_q;
  assign bus.rd_ptr        = rd_ptr_q;
  assign bus.push          = push;
  assign bus.pop           = pop;
  assign bus.fifo_count    = count_q;
  assign bus.full          = full_q;
  assign bus.empty         = empty_q;
  // Thresholds act combinationally so a threshold change is seen at once.
  assign bus.almost_full   = (count_q >= bus.th_af);
  assign bus.almost_empty  = (count_q <= bus.th_ae);
  assign bus.err_overflow  = ovf_q;
  assign bus.err_underflow = unf_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
module tb_fifo_ctrl;
  localparam int MEM = 4;
  localparam int PL  = 3;

  logic clk = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk = ~clk;

  fifo_ctrl_if #(.PTR_L(PL)) bus();

  fifo_ctrl #(.MEM_SIZE(MEM), .WORD_SIZE(6), .PTR_L(PL)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  // Stand-in for the memory bank so data ordering through the pointers
  // can be observed.
  logic [5:0] mem [0:7];
  logic [5:0] wdata;
  always @(posedge clk) if (bus.push) mem[bus.wr_ptr] <= wdata;

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, pointers as modular counters.
  int q[$];
  int wr_m = 0, rd_m = 0, ovf_m = 0, unf_m = 0;
  bit valid = 1'b0;

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then
  // advance the model across the rising edge and check registered state.
  task automatic cyc(input bit pr, input bit po, input bit rn);
    bit ep, eo;
    int n;
    @(negedge clk);
    bus.push_req = pr;
    bus.pop_req  = po;
    reset_L      = rn;
    wdata        = 6'($urandom);
    #1;
    n  = q.size();
    ep = rn && pr && (n != MEM);
    eo = rn && po && (n != 0);
    chk("push", int'(bus.push), int'(ep));
    chk("pop",  int'(bus.pop),  int'(eo));
    if (valid) begin
      chk("almost_full",  int'(bus.almost_full),  int'(n >= int'(bus.th_af)));
      chk("almost_empty", int'(bus.almost_empty), int'(n <= int'(bus.th_ae)));
      if (eo) chk("rdata", int'(mem[bus.rd_ptr]), q[0]);
    end
    @(posedge clk);
    #1;
    if (!rn) begin
      q.delete();
      wr_m = 0; rd_m = 0; ovf_m = 0; unf_m = 0;
      valid = 1'b1;
    end else begin
      if (pr && n == MEM) ovf_m = 1;
      if (po && n == 0)   unf_m = 1;
      if (eo) begin
        void'(q.pop_front());
        rd_m = (rd_m + 1) % MEM;
      end
      if (ep) begin
        q.push_back(int'(wdata));
        wr_m = (wr_m + 1) % MEM;
      end
    end
    if (valid) begin
      chk("wr_ptr",        int'(bus.wr_ptr),        wr_m);
      chk("rd_ptr",        int'(bus.rd_ptr),        rd_m);
      chk("fifo_count",    int'(bus.fifo_count),    q.size());
      chk("full",          int'(bus.full),          int'(q.size() == MEM));
      chk("empty",         int'(bus.empty),         int'(q.size() == 0));
      chk("err_overflow",  int'(bus.err_overflow),  ovf_m);
      chk("err_underflow", int'(bus.err_underflow), unf_m);
    end
  endtask

  initial begin
    bus.push_req = 1'b0;
    bus.pop_req  = 1'b0;
    bus.th_af    = 3'd3;
    bus.th_ae    = 3'd1;
    wdata        = '0;

    // Reset held two cycles with a push request pending.
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    // Fill to full, then one overflowing push.
    repeat (5) cyc(1, 0, 1);
    // Drain to empty, then one underflowing pop.
    repeat (5) cyc(0, 1, 1);
    // Data ordering through the memory.
    repeat (4) cyc(1, 0, 1);
    repeat (4) cyc(0, 1, 1);
    // Simultaneous requests at count 2 for 3 cycles.
    repeat (2) cyc(1, 0, 1);
    repeat (3) cyc(1, 1, 1);
    // Thresholds: count 3, back to 2, then lower th_af at count 2.
    cyc(1, 0, 1);
    cyc(0, 1, 1);
    bus.th_af = 3'd2;
    cyc(0, 0, 1);
    bus.th_af = 3'd3;
    // Full with both requests, then empty with both requests.
    repeat (2) cyc(1, 0, 1);
    cyc(1, 1, 1);
    repeat (3) cyc(0, 1, 1);
    cyc(1, 1, 1);
    // Reset mid-operation at count 3 with overflow set, then resume.
    repeat (2) cyc(1, 0, 1);
    cyc(1, 0, 0);
    repeat (3) cyc(1, 0, 1);

    // Randomized traffic with occasional threshold changes and resets.
    repeat (600) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.th_af = 3'($urandom_range(0, 5));
        bus.th_ae = 3'($urandom_range(0, 5));
      end
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
          $urandom_range(0, 49) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
